// File: rtl/sw_alloc.sv
// Switch allocator for one router output port.
// Arbitrates requesters, locks the output to a packet owner from head to tail,
// and tracks downstream per-VC credits.
// Build option: define SW_ALLOC_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) and no pointer register is built.
module sw_alloc #(
    parameter int unsigned N_IN     = 5,
    parameter int unsigned N_VC     = 4,
    parameter int unsigned VCW      = 2,
    parameter int unsigned CRED_MAX = 4,
    parameter int unsigned CW       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       req,
    input  logic [N_IN*VCW-1:0]   req_vc,
    input  logic [N_IN-1:0]       tail,
    input  logic [N_VC-1:0]       credit_in,
    output logic [N_IN-1:0]       grant,
    output logic                  send,
    output logic [VCW-1:0]        out_vc,
    output logic                  busy,
    output logic [N_VC*CW-1:0]    credit_cnt,
    output logic                  cred_err
);

    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [VCW-1:0]  lock_vc_q, lock_vc_d;
    logic [CW-1:0]   cred_q [N_VC];
    logic [CW-1:0]   cred_d [N_VC];
    logic            cred_err_q, cred_err_d;

    logic [N_VC-1:0] cred_nz;
    logic [N_IN-1:0] elig;
    logic            win_vld;
    logic [IW-1:0]   win_idx;
`ifdef SW_ALLOC_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;
`endif

    // Per-VC credit availability and per-requester eligibility for a head grant
    always_comb begin
        cred_nz = '0;
        elig    = '0;
        for (int v = 0; v < N_VC; v++) begin
            cred_nz[v] = (cred_q[v] != '0);
        end
        for (int i = 0; i < N_IN; i++) begin
            for (int v = 0; v < N_VC; v++) begin
                if (req[i] && cred_nz[v] && (req_vc[i*VCW +: VCW] == VCW'(v))) begin
                    elig[i] = 1'b1;
                end
            end
        end
    end

`ifdef SW_ALLOC_RR_EN
    // Round-robin pick: first eligible requester at or after ptr, with wrap
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_IN)) begin
                idx = idx - int'(N_IN);
            end
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end
`else
    // Fixed-priority pick: lowest eligible index wins
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!win_vld && elig[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end
`endif

    // Grant generation and lock next-state; everything is held quiet during reset
    always_comb begin
        logic lock_ok;
        grant     = '0;
        send      = 1'b0;
        out_vc    = '0;
        state_d   = state_q;
        owner_d   = owner_q;
        lock_vc_d = lock_vc_q;
        lock_ok   = 1'b0;
`ifdef SW_ALLOC_RR_EN
        ptr_d     = ptr_q;
`endif
        for (int v = 0; v < N_VC; v++) begin
            if (cred_nz[v] && (lock_vc_q == VCW'(v))) begin
                lock_ok = 1'b1;
            end
        end
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant  = N_IN'(1) << win_idx;
                        send   = 1'b1;
                        out_vc = req_vc[int'(win_idx)*VCW +: VCW];
`ifdef SW_ALLOC_RR_EN
                        ptr_d  = (win_idx == IW'(N_IN - 1)) ? '0 : win_idx + IW'(1);
`endif
                        if (!(|(tail & (N_IN'(1) << win_idx)))) begin
                            state_d   = LOCKED;
                            owner_d   = win_idx;
                            lock_vc_d = req_vc[int'(win_idx)*VCW +: VCW];
                        end
                    end
                end
                LOCKED: begin
                    if ((|(req & (N_IN'(1) << owner_q))) && lock_ok) begin
                        grant  = N_IN'(1) << owner_q;
                        send   = 1'b1;
                        out_vc = lock_vc_q;
                        if (|(tail & (N_IN'(1) << owner_q))) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Credit counters: send consumes, credit_in returns, overflow is flagged and saturated
    always_comb begin
        logic dec;
        logic inc;
        cred_err_d = cred_err_q;
        dec        = 1'b0;
        inc        = 1'b0;
        for (int v = 0; v < N_VC; v++) begin
            cred_d[v] = cred_q[v];
            dec = send && (out_vc == VCW'(v));
            inc = credit_in[v];
            if (inc && !dec) begin
                if (cred_q[v] == CW'(CRED_MAX)) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CW'(1);
                end
            end else if (dec && !inc) begin
                cred_d[v] = cred_q[v] - CW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            lock_vc_q  <= '0;
            cred_err_q <= 1'b0;
            for (int v = 0; v < N_VC; v++) begin
                cred_q[v] <= CW'(CRED_MAX);
            end
`ifdef SW_ALLOC_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_vc_q  <= lock_vc_d;
            cred_err_q <= cred_err_d;
            for (int v = 0; v < N_VC; v++) begin
                cred_q[v] <= cred_d[v];
            end
`ifdef SW_ALLOC_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Status outputs
    always_comb begin
        busy     = reset && (state_q == LOCKED);
        cred_err = cred_err_q;
        credit_cnt = '0;
        for (int v = 0; v < N_VC; v++) begin
            credit_cnt[v*CW +: CW] = cred_q[v];
        end
    end

endmodule
